sprite_capture: RTL and testbench
=================================

Name: sprite_capture

Overview:
- Writer side of the 64x64 sprite memory; the sprite overlay filter is the reader.
- On a capture request, the block waits for the next frame start. During that frame, it copies the RGB444 camera pixels inside a fixed 64x64 window into sprite RAM, one word per pixel.
- It sits between the camera pixel stream (de/x/y/rgb) and the write port of the 4096x12 sprite RAM.
- Its output lets a live snapshot replace the sprite image.

Parameters:
- SPRITE_X, 100, left column of the capture window in screen coordinates.
- SPRITE_Y, 200, top row of the capture window.
- KEY_COLOR, 12'h0F0, chroma-key colour; used only when SPRITE_CAPTURE_KEY_EN is defined.

Ports:
- clk  in  1  pixel clock; all logic rising-edge.
- reset  in  1  synchronous, active-high reset.
- cap_req  in  1  single-cycle capture request pulse.
- de  in  1  pixel valid / display enable.
- x  in  10  pixel column.
- y  in  10  pixel row.
- rgb  in  12  pixel colour {r[3:0],g[3:0],b[3:0]}.
- wr_en  out  1  sprite RAM write strobe.
- wr_addr  out  12  sprite RAM address.
- wr_data  out  12  sprite RAM data.
- busy  out  1  high in ARMED or CAPTURE.
- done  out  1  one-cycle pulse when a capture ends.
- err  out  1  sticky; set if the last capture wrote fewer than 4096 words. Cleared on the next accepted cap_req.

Behaviour:
- Reset: synchronous, active-high. All outputs go to 0, the state goes to IDLE, and the write counter clears. Reset mid-capture abandons it with no done pulse; the RAM is left partially written.
- Frame start (fs) is defined as de && x==0 && y==0.
- In-window (win) is defined as de && x in [SPRITE_X, SPRITE_X+63] && y in [SPRITE_Y, SPRITE_Y+63]. Comparisons are done at 11 bits, so no wrap occurs.
- IDLE:
  - cap_req -> ARMED.
  - The counter clears and err clears.
  - A cap_req together with fs in the same cycle still arms only; that frame is not captured.
- ARMED: fs -> CAPTURE. The fs pixel itself is processed in CAPTURE rules if it lies in the window (SPRITE_X=SPRITE_Y=0).
- CAPTURE: each win pixel produces a registered write on the next cycle.
  - wr_en=1.
  - wr_addr = {dy[5:0], dx[5:0]}, where dx = x-SPRITE_X and dy = y-SPRITE_Y. This equals dy*64+dx, matching the reader's indexing.
  - wr_data = rgb.
  - The write counter (13 bits) increments for each write.
- Latency: a fixed 1 cycle from input pixel to write strobe. There is no backpressure; the RAM accepts a write every cycle.
- Normal end: the write for pixel (SPRITE_X+63, SPRITE_Y+63) is emitted. In the same cycle as that write, done=1 and the state goes to IDLE.
- Abnormal end: a second fs arrives while in CAPTURE, for example because the window lies partly off-screen.
  - The state goes to IDLE and done pulses the cycle after that fs.
  - err is set if the counter is not 4096.
  - That fs pixel is not written.
- cap_req in ARMED or CAPTURE is ignored.
- busy is registered: it equals 1 in the cycle after cap_req is accepted and stays 1 through the cycle before done.
- wr_addr and wr_data hold their last value when wr_en=0.
- Non-window pixels and pixels with de=0 never write.

Optional Feature:
- Macro: SPRITE_CAPTURE_KEY_EN.
- Defined: a pixel with rgb==KEY_COLOR is written as 12'h000, which the overlay treats as transparent/black. The counter still increments and the address is unchanged.
- Undefined: rgb is written unmodified and the KEY_COLOR parameter is unused.

Test Plan:
- Full capture: cap_req, then a 640x480 raster with rgb = {x[5:0], y[5:0]}. Required response:
  - exactly 4096 writes;
  - write at (100,200) gives addr 0x000; write at (163,263) gives addr 0xFFF with data {6'd35, 6'd7};
  - done pulses once, in the same cycle as the last write; err=0; busy falls.
- Arming: cap_req mid-frame. Required response: no writes until the next fs. cap_req in the same cycle as fs: the first captured frame is the one after.
- Ignored request: cap_req pulsed during CAPTURE. Required response: no restart, still 4096 writes, a single done.
- Off-screen window: SPRITE_Y=450 in a 480-line frame. Required response: 30*64=1920 writes; done pulses the cycle after the next fs; err=1. The next cap_req clears err.
- Reset mid-capture: reset asserted after 1000 writes. Required response: next cycle wr_en=0, busy=0, done=0, err=0, and no done pulse. A subsequent request captures normally.
- KEY_EN: with the macro defined, window pixels at rgb=12'h0F0 are written as 12'h000 and others unchanged; with it undefined, 12'h0F0 is written as-is.

Source files
------------

// File: rtl/sprite_capture.sv
// Copies a 64x64 RGB444 window of one camera frame into the sprite RAM write port.
// Build option: define SPRITE_CAPTURE_KEY_EN to write KEY_COLOR pixels as 12'h000.
module sprite_capture #(
   parameter int          SPRITE_X  = 100,
   parameter int          SPRITE_Y  = 200,
   parameter logic [11:0] KEY_COLOR = 12'h0F0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cap_req,
   input  logic        de,
   input  logic [9:0]  x,
   input  logic [9:0]  y,
   input  logic [11:0] rgb,
   output logic        wr_en,
   output logic [11:0] wr_addr,
   output logic [11:0] wr_data,
   output logic        busy,
   output logic        done,
   output logic        err
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] ARMED   = 2'd1;
   localparam logic [1:0] CAPTURE = 2'd2;

   // Window bounds at 11 bits so SPRITE_X+63 never wraps past column 1023.
   localparam logic [10:0] X_LO = 11'(SPRITE_X);
   localparam logic [10:0] X_HI = 11'(SPRITE_X + 63);
   localparam logic [10:0] Y_LO = 11'(SPRITE_Y);
   localparam logic [10:0] Y_HI = 11'(SPRITE_Y + 63);

   localparam logic [11:0] LAST_ADDR  = 12'hFFF;
   localparam logic [12:0] FULL_COUNT = 13'd4096;

   logic [1:0]  state;
   logic [12:0] wr_cnt;
   logic [10:0] x11;
   logic [10:0] y11;
   logic        fs;
   logic        win;
   logic [5:0]  dx;
   logic [5:0]  dy;
   logic [11:0] pix_addr;
   logic [11:0] pix_data;
   logic        do_write;
   logic        last_pix;

   assign x11 = {1'b0, x};
   assign y11 = {1'b0, y};
   assign fs  = de && (x == 10'd0) && (y == 10'd0);
   assign win = de && (x11 >= X_LO) && (x11 <= X_HI) && (y11 >= Y_LO) && (y11 <= Y_HI);

   // Low six bits of the offset are all the address needs; the window is exactly 64 wide.
   assign dx       = x[5:0] - X_LO[5:0];
   assign dy       = y[5:0] - Y_LO[5:0];
   assign pix_addr = {dy, dx};

`ifdef SPRITE_CAPTURE_KEY_EN
   assign pix_data = (rgb == KEY_COLOR) ? 12'h000 : rgb;
`else
   logic unused_key;
   assign unused_key = ^KEY_COLOR;
   assign pix_data   = rgb;
`endif

   // The frame-start pixel that opens a capture is still eligible; a later one ends it unwritten.
   assign do_write = win && (((state == ARMED) && fs) || ((state == CAPTURE) && !fs));
   assign last_pix = do_write && (pix_addr == LAST_ADDR);

   always_ff @(posedge clk) begin
      // NOTE: every register here is state, so all assignments are non-blocking; the
      // write port is reset too, giving a defined address/data on the RAM bus after reset.
      if (reset) begin
         state   <= IDLE;
         wr_cnt  <= '0;
         wr_en   <= 1'b0;
         wr_addr <= '0;
         wr_data <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         err     <= 1'b0;
      end else begin
         wr_en <= do_write;
         done  <= 1'b0;

         if (do_write) begin
            wr_addr <= pix_addr;
            wr_data <= pix_data;
            wr_cnt  <= wr_cnt + 13'd1;
         end

         case (state)
            IDLE: begin
               if (cap_req) begin
                  state  <= ARMED;
                  busy   <= 1'b1;
                  err    <= 1'b0;
                  wr_cnt <= '0;
               end
            end
            ARMED: begin
               if (fs) state <= CAPTURE;
            end
            CAPTURE: begin
               if (fs) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  err   <= (wr_cnt != FULL_COUNT);
               end else if (last_pix) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  err   <= ((wr_cnt + 13'd1) != FULL_COUNT);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sprite_capture.sv
// Directed bench for sprite_capture: compressed rasters around the window, plus an
// off-screen-window instance (SPRITE_Y=450) sharing the pixel stream.
module tb_sprite_capture;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cap_req = 1'b0;
   logic        cap_req2 = 1'b0;
   logic        de = 1'b0;
   logic [9:0]  x = '0;
   logic [9:0]  y = '0;
   logic [11:0] rgb = '0;

   logic        wr_en, busy, done, err;
   logic [11:0] wr_addr, wr_data;
   logic        wr_en2, busy2, done2, err2;
   logic [11:0] wr_addr2, wr_data2;

`ifdef SPRITE_CAPTURE_KEY_EN
   localparam logic [11:0] KEY_EXP = 12'h000;
`else
   localparam logic [11:0] KEY_EXP = 12'h0F0;
`endif
   localparam logic [11:0] KEY_ADDR = 12'h28A;  // pixel (110,210) -> dy=10, dx=10

   int n_cmp = 0;
   int n_bad = 0;

   sprite_capture dut (
      .clk(clk), .reset(reset), .cap_req(cap_req), .de(de), .x(x), .y(y), .rgb(rgb),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .busy(busy), .done(done), .err(err)
   );

   sprite_capture #(.SPRITE_Y(450)) dut2 (
      .clk(clk), .reset(reset), .cap_req(cap_req2), .de(de), .x(x), .y(y), .rgb(rgb),
      .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2),
      .busy(busy2), .done(done2), .err(err2)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Expected data for a window write, given rgb = {x[5:0], y[5:0]} and the key pixel.
   function automatic logic [11:0] exp_data(input logic [11:0] a);
      logic [5:0] xs, ys;
      xs = a[5:0] + 6'd36;   // (dx + 100) mod 64
      ys = a[11:6] + 6'd8;   // (dy + 200) mod 64
      return (a == KEY_ADDR) ? KEY_EXP : {xs, ys};
   endfunction

   // Write monitor, sampled on the falling edge.
   int          wcnt, dcnt, bad_addr, bad_data, wcnt2, dcnt2;
   logic [11:0] first_addr, first_data, key_data, done_addr, done_data;
   logic        done_wr, done_busy;

   always @(negedge clk) begin
      if (wr_en) begin
         if (wcnt == 0) begin
            first_addr = wr_addr;
            first_data = wr_data;
         end
         if (wr_addr != 12'(wcnt)) bad_addr++;
         if (wr_data != exp_data(wr_addr)) bad_data++;
         if (wr_addr == KEY_ADDR) key_data = wr_data;
         wcnt++;
      end
      if (done) begin
         dcnt++;
         done_wr   = wr_en;
         done_addr = wr_addr;
         done_data = wr_data;
         done_busy = busy;
      end
      if (wr_en2) wcnt2++;
      if (done2) dcnt2++;
   end

   task automatic clear_mon();
      wcnt = 0; dcnt = 0; bad_addr = 0; bad_data = 0; wcnt2 = 0; dcnt2 = 0;
      first_addr = 'x; first_data = 'x; key_data = 'x;
      done_addr = 'x; done_data = 'x; done_wr = 1'b0; done_busy = 1'bx;
   endtask

   // One pixel cycle: drive at negedge+1, return just after the following negedge.
   task automatic pix(input logic d, input int xx, input int yy, input logic req);
      logic [9:0] xv, yv;
      xv = 10'(xx);
      yv = 10'(yy);
      de      = d;
      x       = xv;
      y       = yv;
      rgb     = (xx == 110 && yy == 210) ? 12'h0F0 : {xv[5:0], yv[5:0]};
      cap_req = req;
      @(negedge clk);
      #1;
      cap_req = 1'b0;
   endtask

   // Frame start, then rows ylo..yhi each with a de=0 cycle and columns 98..165.
   // req_at: -1 none, 0 with the frame-start pixel, n>0 on the n-th pixel after it.
   task automatic frame(input int ylo, input int yhi, input int req_at);
      int n;
      n = 0;
      pix(1'b1, 0, 0, req_at == 0);
      for (int yy = ylo; yy <= yhi; yy++) begin
         n++;
         pix(1'b0, 130, yy, req_at == n);
         for (int xx = 98; xx <= 165; xx++) begin
            n++;
            pix(1'b1, xx, yy, req_at == n);
         end
      end
      pix(1'b0, 0, 0, 1'b0);
   endtask

   initial begin
      clear_mon();
      @(negedge clk); #1;
      pix(1'b0, 0, 0, 1'b0);
      pix(1'b0, 0, 0, 1'b0);
      check("rst_wr_en", wr_en, 0);
      check("rst_wr_addr", wr_addr, 0);
      check("rst_wr_data", wr_data, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      reset = 1'b0;

      // Full capture
      pix(1'b0, 0, 0, 1'b1);
      check("arm_busy", busy, 1);
      frame(198, 265, -1);
      check("full_writes", wcnt, 4096);
      check("full_dones", dcnt, 1);
      check("full_first_addr", first_addr, 12'h000);
      check("full_first_data", first_data, 12'h908);
      check("full_done_with_wr", done_wr, 1);
      check("full_done_addr", done_addr, 12'hFFF);
      check("full_done_data", done_data, 12'h8C7);
      check("full_done_busy", done_busy, 0);
      check("full_addr_seq_bad", bad_addr, 0);
      check("full_data_bad", bad_data, 0);
      check("full_key_data", key_data, KEY_EXP);
      check("full_err", err, 0);
      check("full_busy_after", busy, 0);

      // Request mid-frame: nothing until the next frame start
      clear_mon();
      frame(198, 265, 500);
      check("mid_arm_writes", wcnt, 0);
      check("mid_arm_busy", busy, 1);
      frame(198, 265, -1);
      check("mid_next_writes", wcnt, 4096);
      check("mid_next_dones", dcnt, 1);

      // Request together with frame start: that frame is skipped
      clear_mon();
      frame(198, 265, 0);
      check("fs_req_writes", wcnt, 0);
      check("fs_req_busy", busy, 1);
      frame(198, 265, -1);
      check("fs_next_writes", wcnt, 4096);
      check("fs_next_dones", dcnt, 1);

      // Request during capture is ignored
      clear_mon();
      pix(1'b0, 0, 0, 1'b1);
      frame(198, 265, 2000);
      check("ign_writes", wcnt, 4096);
      check("ign_dones", dcnt, 1);
      check("ign_addr_seq_bad", bad_addr, 0);
      check("ign_busy_after", busy, 0);

      // Reset after 1000 writes
      clear_mon();
      pix(1'b0, 0, 0, 1'b1);
      pix(1'b1, 0, 0, 1'b0);
      for (int k = 0; k < 1000; k++) pix(1'b1, 100 + (k % 64), 200 + (k / 64), 1'b0);
      check("rst_mid_writes", wcnt, 1000);
      reset = 1'b1;
      pix(1'b1, 140, 215, 1'b0);
      reset = 1'b0;
      check("rst_mid_wr_en", wr_en, 0);
      check("rst_mid_busy", busy, 0);
      check("rst_mid_done", done, 0);
      check("rst_mid_err", err, 0);
      for (int k = 0; k < 100; k++) pix(1'b1, 141 + (k % 23), 215 + (k / 23), 1'b0);
      frame(198, 265, -1);
      check("rst_after_writes", wcnt, 1000);
      check("rst_after_dones", dcnt, 0);
      clear_mon();
      pix(1'b0, 0, 0, 1'b1);
      frame(198, 265, -1);
      check("rst_recap_writes", wcnt, 4096);
      check("rst_recap_dones", dcnt, 1);
      check("rst_recap_data_bad", bad_data, 0);

      // Off-screen window (second instance, rows 450..479 of a 480-line frame)
      clear_mon();
      cap_req2 = 1'b1;
      pix(1'b0, 0, 0, 1'b0);
      cap_req2 = 1'b0;
      check("off_busy", busy2, 1);
      frame(448, 479, -1);
      check("off_writes", wcnt2, 1920);
      check("off_no_early_done", dcnt2, 0);
      pix(1'b1, 0, 0, 1'b0);
      check("off_done", done2, 1);
      check("off_err", err2, 1);
      check("off_fs_not_written", wr_en2, 0);
      check("off_busy_after", busy2, 0);
      check("off_main_writes", wcnt, 0);
      cap_req2 = 1'b1;
      pix(1'b0, 5, 5, 1'b0);
      cap_req2 = 1'b0;
      check("off_err_cleared", err2, 0);
      check("off_rearm_busy", busy2, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
